// File: rtl/multicycle_add_sub.sv
// multicycle_add_sub: add/subtract engine that processes CHUNK bits per clock
// and completes a WIDTH-bit operation in N = WIDTH/CHUNK RUN cycles.
// WIDTH must be an integer multiple of CHUNK; CHUNK == WIDTH gives one RUN cycle.
// Optional build macro: ADD_SUB_SAT_EN -- saturate Sum to the signed max/min
// when the signed result overflows (Ovf and Cout are reported unchanged).
module multicycle_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CTRL,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched operands; b_p0 holds ~B for subtraction so RUN only ever adds
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             carry_p0;
  logic [IDX_W-1:0] idx_p0;
  // Slice results accumulated across RUN cycles
  logic [WIDTH-1:0] res_p1;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   slice_ext;
  logic             c_msb_in;
  logic             c_msb_out;
  logic [WIDTH-1:0] full_res;
  logic [WIDTH-1:0] sum_nxt;

`ifdef ADD_SUB_SAT_EN
  // On signed overflow the wrapped sign is the inverse of the true sign,
  // so a wrapped negative value means the true result was positive.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped,
                                                input logic             ovf);
    logic signed [WIDTH-1:0] smax;
    logic signed [WIDTH-1:0] smin;
    smax = {1'b0, {(WIDTH-1){1'b1}}};
    smin = {1'b1, {(WIDTH-1){1'b0}}};
    if (!ovf)
      return wrapped;
    return wrapped[WIDTH-1] ? smax : smin;
  endfunction
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (idx_p0 == LAST_IDX);

  // Current slice addition and the assembled full-width result
  always_comb begin
    a_slice   = a_p0[CHUNK*int'(idx_p0) +: CHUNK];
    b_slice   = b_p0[CHUNK*int'(idx_p0) +: CHUNK];
    slice_ext = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_p0};
    c_msb_out = slice_ext[CHUNK];
    // Carry into the slice's top bit, recovered from its sum bit and operands
    c_msb_in  = slice_ext[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];
    full_res  = res_p1;
    full_res[CHUNK*int'(idx_p0) +: CHUNK] = slice_ext[CHUNK-1:0];
`ifdef ADD_SUB_SAT_EN
    sum_nxt   = saturate(full_res, c_msb_in ^ c_msb_out);
`else
    sum_nxt   = full_res;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice-by-slice accumulation and final result commit
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_p0 <= 1'b0;
      idx_p0   <= '0;
      res_p1   <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Ovf      <= 1'b0;
    end else if (accept) begin
      a_p0     <= A;
      b_p0     <= CTRL ? ~B : B;
      carry_p0 <= CTRL;
      idx_p0   <= '0;
    end else if (state == RUN) begin
      carry_p0 <= c_msb_out;
      res_p1   <= full_res;
      idx_p0   <= idx_p0 + 1'b1;
      if (last) begin
        Sum  <= sum_nxt;
        Cout <= c_msb_out;
        Ovf  <= c_msb_in ^ c_msb_out;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Testbench for multicycle_add_sub: WIDTH=16/CHUNK=4 instance checked every
// cycle against an arithmetic reference, plus a WIDTH=8/CHUNK=8 instance.
`timescale 1ns/1ps
module tb_multicycle_add_sub;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;
`ifdef ADD_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ctrl;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         start1;
  logic [7:0]   a1;
  logic [7:0]   b1;
  logic         ctrl1;
  logic         busy1;
  logic         done1;
  logic [7:0]   sum1;
  logic         cout1;
  logic         ovf1;

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .CTRL(ctrl),
    .busy(busy), .done(done), .Sum(sum), .Cout(cout), .Ovf(ovf)
  );

  multicycle_add_sub #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .CTRL(ctrl1),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference result from signed/unsigned integer arithmetic: {ovf, cout, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sub);
    int sx, sy, r, ux, uy;
    logic [W-1:0] s;
    logic co, ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    r  = sub ? (sx - sy) : (sx + sy);
    ov = (r > (2**(W-1) - 1)) || (r < -(2**(W-1)));
    co = sub ? (ux >= uy) : ((ux + uy) >= 2**W);
    s  = r[W-1:0];
    if (SAT && ov)
      s = (r > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    return {ov, co, s};
  endfunction

  // Transaction-level reference: remaining RUN cycles, done flag, held result
  bit           m_valid = 1'b0;
  int           m_rem   = 0;
  bit           m_done  = 1'b0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;
  logic [W+1:0] m_pend  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_rem   = 0;
      m_done  = 1'b0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        {m_ovf, m_cout, m_sum} = m_pend;
      end
    end else if (start) begin
      m_rem  = N;
      m_pend = model(a, b, ctrl);
    end
  end

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_busy", 32'(busy), 32'(m_rem > 0));
      chk("cmp_done", 32'(done), 32'(m_done));
      chk("cmp_sum",  32'(sum),  32'(m_sum));
      chk("cmp_cout", 32'(cout), 32'(m_cout));
      chk("cmp_ovf",  32'(ovf),  32'(m_ovf));
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input string nm);
    int cyc   = 0;
    int nbusy = 0;
    bit seen  = 1'b0;
    @(negedge clk);
    a = x; b = y; ctrl = s; start = 1'b1;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
      ctrl  = 1'($urandom);
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(N + 1));
    chk({nm, "_busycyc"}, 32'(nbusy), 32'(N));
    chk({nm, "_sum"},  32'(sum),  32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"},  32'(ovf),  32'(eo));
  endtask

  initial begin
    int ndone;
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ctrl = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ctrl1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum",  32'(sum),  32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_ovf",  32'(ovf),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Hand-computed operations
    run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "add_small");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, "add_ovf");
    run_op(16'h0006, 16'h0007, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
    run_op(16'h000C, 16'h0005, 1'b1, 16'h0007, 1'b1, 1'b0, "sub_noborrow");
    run_op(16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    run_op(16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, "add_negovf");
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_equal");

    // Starts during RUN and DONE are ignored
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; ctrl = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h0F0F; b = 16'hFFFF; ctrl = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ign_sum", 32'(sum), 32'h3333);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_busy",  32'(busy),  32'h0);

    // Reset on the second RUN cycle aborts the operation
    @(negedge clk);
    a = 16'h00F0; b = 16'h0F0F; ctrl = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_sum",  32'(sum),  32'h0);
    chk("abort_cout", 32'(cout), 32'h0);
    chk("abort_ovf",  32'(ovf),  32'h0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_ndone", 32'(ndone), 32'd0);
    run_op(16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, "after_abort");

    // Single-chunk configuration: one RUN cycle
    @(negedge clk);
    a1 = 8'h7F; b1 = 8'h01; ctrl1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_busy", 32'(busy1), 32'h1);
    chk("n1_done0", 32'(done1), 32'h0);
    @(negedge clk);
    chk("n1_done", 32'(done1), 32'h1);
    chk("n1_sum",  32'(sum1),  SAT ? 32'h7F : 32'h80);
    chk("n1_cout", 32'(cout1), 32'h0);
    chk("n1_ovf",  32'(ovf1),  32'h1);
    @(negedge clk);
    a1 = 8'h05; b1 = 8'h09; ctrl1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("n1b_done", 32'(done1), 32'h1);
    chk("n1b_sum",  32'(sum1),  32'hFC);
    chk("n1b_cout", 32'(cout1), 32'h0);
    chk("n1b_ovf",  32'(ovf1),  32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_add_sub.md
MULTICYCLE_ADD_SUB -- requirements
Module: multicycle_add_sub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits processed per clock; N = WIDTH/CHUNK chunk cycles per operation.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request an operation; sampled only in IDLE.
REQ-006 A  input  WIDTH  first operand; sampled when start is accepted.
REQ-007 B  input  WIDTH  second operand; sampled when start is accepted.
REQ-008 CTRL  input  1  0 = A+B, 1 = A-B; sampled when start is accepted.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 Sum  output  WIDTH  result; held until the next completion.
REQ-012 Cout  output  1  carry out of the MSB (subtract: 1 = no borrow, A >= B unsigned).
REQ-013 Ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge SHALL latch A, B and CTRL, load carry-in = CTRL, clear the chunk index, and move to RUN.
REQ-016 Subtraction SHALL add A to bitwise-inverted B with carry-in 1.
REQ-017 Each RUN edge SHALL add one CHUNK-bit slice (LSB slice first) with the carry from the previous slice, and store the slice result and carry-out.
REQ-018 The Nth RUN edge SHALL update Sum, Cout and Ovf together and move to DONE.
REQ-019 Ovf SHALL be the XOR of the carry into the MSB and the carry out of the MSB.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL return to IDLE unconditionally.
REQ-021 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-022 Latency: done SHALL be high in the cycle that begins N edges after the edge that accepted start.
REQ-023 A start arriving in RUN or DONE SHALL be ignored and not queued; A, B and CTRL changes outside acceptance SHALL have no effect.
REQ-024 Sum, Cout and Ovf SHALL change only at the final RUN edge or at reset.
REQ-025 N=1 (CHUNK=WIDTH) SHALL be legal: the operation is one RUN cycle.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and clear Sum, Cout, Ovf, busy, done, the internal slice results and the carry register to 0.
REQ-027 rst during RUN or DONE SHALL abort the operation with no done pulse; rst SHALL take priority over start.

Configuration
REQ-028 Macro ADD_SUB_SAT_EN: when defined, on Ovf=1 Sum SHALL saturate to the signed maximum (0111...1) if the true result is positive, or the signed minimum (1000...0) if negative; Ovf and Cout stay as computed.
REQ-029 When ADD_SUB_SAT_EN is not defined, Sum SHALL be the wrapped WIDTH-bit result; the ports are identical in both builds.

Verification (WIDTH=16, CHUNK=4)
REQ-030 start, A=0x0001, B=0x0002, CTRL=0 -> done 4 cycles later; Sum=0x0003, Cout=0, Ovf=0; busy high for exactly 4 cycles.
REQ-031 A=0xFFFF, B=0x0001, CTRL=0 -> Sum=0x0000, Cout=1, Ovf=0; the carry ripples across all 4 chunk cycles.
REQ-032 A=0x7FFF, B=0x0001, CTRL=0 -> Ovf=1, Cout=0; Sum=0x8000 without the macro, Sum=0x7FFF with ADD_SUB_SAT_EN.
REQ-033 A=0x0006, B=0x0007, CTRL=1 -> Sum=0xFFFF, Cout=0, Ovf=0; then A=0x000C, B=0x0005, CTRL=1 -> Sum=0x0007, Cout=1.
REQ-034 A second start with new operands during RUN -> ignored; exactly one done, carrying the first operation's result.
REQ-035 rst asserted on the 2nd RUN cycle -> no done; Sum/Cout/Ovf=0; the next start completes normally after 4 cycles.
